// File: rtl/tmds_decoder_channel.sv
// ---------------------------------------------------------------------------
// tmds_decoder_channel
//
// Receive side of one TMDS data channel (HDMI/DVI). Takes 10-bit words from an
// external 1:10 deserializer running at pixel rate. It steers the deserializer
// bitslip until the word boundary lines up with the control tokens sent during
// blanking. It then decodes every word into video data, control data and a
// data-enable for the RGB capture path.
//
// Optional feature:
//   TMDS_DISPARITY_CHECK_EN - when defined, adds a running-disparity check on
//   data words that drives disp_err. When undefined, disp_err is tied to 0.
//
// Ports:
//   clk         in   1  pixel clock (parallel word rate)
//   rst         in   1  asynchronous, active-high reset
//   sym_in      in  10  deserialized word, bit 0 = first bit on the wire
//   bitslip     out  1  one-cycle request to rotate the deserializer by 1 bit
//   locked      out  1  word alignment achieved
//   slip_count  out  4  slips issued so far, 0..9, wraps 9 -> 0
//   vd          out  8  decoded video data
//   cd          out  2  decoded control data {C1,C0}
//   vde         out  1  1 = data symbol, 0 = control token
//   disp_err    out  1  disparity violation pulse, aligned with vd
//
// Alignment FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_SEARCH | unaligned; looking for a run of tokens, slip on window expiry
//   S_WAIT   | deserializer settling after a slip; token runs ignored
//   S_LOCKED | aligned; each token run refreshes the window, expiry drops lock
//
// Pipeline: sym_in -> r_sym (stage 1) -> r_vd/r_cd/r_vde (stage 2).
// Decode runs every cycle and does not depend on lock.
// ---------------------------------------------------------------------------
module tmds_decoder_channel #(
    parameter int LOCK_TOKENS   = 8,
    parameter int SEARCH_WINDOW = 2048,
    parameter int SLIP_WAIT     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sym_in,
    output logic       bitslip,
    output logic       locked,
    output logic [3:0] slip_count,
    output logic [7:0] vd,
    output logic [1:0] cd,
    output logic       vde,
    output logic       disp_err
);

    localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
    localparam int WIN_W  = $clog2(SEARCH_WINDOW);
    localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_WAIT   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [9:0]        r_sym;
    logic [7:0]        r_vd;
    logic [1:0]        r_cd;
    logic              r_vde;

    logic [RUN_W-1:0]  r_run;
    logic [WIN_W-1:0]  r_win;
    logic [WAIT_W-1:0] r_wait;
    logic [3:0]        r_slip_cnt;

    logic              w_is_tok;
    logic [1:0]        w_tok_cd;
    logic [7:0]        w_d;
    logic [7:0]        w_vd;
    logic              w_run_ev;
    logic              w_win_exp;
    logic              w_bitslip;

    // ------------------------------------------------------------------
    // Token detect and data decode on the stage-1 word
    // ------------------------------------------------------------------
    always_comb begin
        w_is_tok = 1'b1;
        w_tok_cd = 2'b00;
        case (r_sym)
            10'b1101010100: w_tok_cd = 2'b00;
            10'b0010101011: w_tok_cd = 2'b01;
            10'b0101010100: w_tok_cd = 2'b10;
            10'b1010101011: w_tok_cd = 2'b11;
            default:        w_is_tok = 1'b0;
        endcase
    end

    // bit 9 flags an inverted payload, bit 8 selects XOR (1) or XNOR (0) chaining
    always_comb begin
        w_d     = r_sym[9] ? ~r_sym[7:0] : r_sym[7:0];
        w_vd    = '0;
        w_vd[0] = w_d[0];
        for (int i = 1; i < 8; i++) begin
            w_vd[i] = r_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sym <= '0;
            r_vd  <= '0;
            r_cd  <= '0;
            r_vde <= 1'b0;
        end else begin
            r_sym <= sym_in;
            if (w_is_tok) begin
                r_vd  <= '0;
                r_cd  <= w_tok_cd;
                r_vde <= 1'b0;
            end else begin
                r_vd  <= w_vd;
                r_vde <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Token run counter. Once saturated, every further token still counts
    // as a run event, so a steady token stream keeps refreshing the window.
    // The counter is held at zero while the deserializer settles.
    // ------------------------------------------------------------------
    assign w_run_ev = w_is_tok && (r_state != S_WAIT) &&
                      (r_run >= RUN_W'(LOCK_TOKENS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= '0;
        end else if ((r_state == S_WAIT) || !w_is_tok) begin
            r_run <= '0;
        end else if (r_run != RUN_W'(LOCK_TOKENS)) begin
            r_run <= r_run + RUN_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Alignment FSM
    // ------------------------------------------------------------------
    assign w_win_exp = (r_win == WIN_W'(SEARCH_WINDOW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A run event takes priority over window expiry in both SEARCH and LOCKED.
    always_comb begin
        w_state_nxt = r_state;
        w_bitslip   = 1'b0;
        case (r_state)
            S_SEARCH: begin
                if (w_run_ev) begin
                    w_state_nxt = S_LOCKED;
                end else if (w_win_exp) begin
                    w_bitslip   = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_wait == WAIT_W'(SLIP_WAIT - 1)) begin
                    w_state_nxt = S_SEARCH;
                end
            end
            S_LOCKED: begin
                if (!w_run_ev && w_win_exp) begin
                    w_state_nxt = S_SEARCH;
                end
            end
            default: begin
                w_state_nxt = S_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_run_ev || (w_state_nxt != r_state) || (r_state == S_WAIT)) begin
            r_win <= '0;
        end else begin
            r_win <= r_win + WIN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait <= '0;
        end else if ((r_state == S_WAIT) && (w_state_nxt == S_WAIT)) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slip_cnt <= '0;
        end else if (w_bitslip) begin
            r_slip_cnt <= (r_slip_cnt == 4'd9) ? 4'd0 : r_slip_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Running disparity check on data words
    // ------------------------------------------------------------------
`ifdef TMDS_DISPARITY_CHECK_EN
    logic signed [5:0] r_acc;
    logic signed [5:0] w_acc_upd;
    logic [3:0]        w_ones;
    logic              w_derr;
    logic              r_derr;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < 10; i++) begin
            w_ones = w_ones + {3'b000, r_sym[i]};
        end
    end

    // accumulator stays within -8..+8 between words, so +/-5 never overflows 6 bits
    assign w_acc_upd = r_acc + $signed({2'b00, w_ones}) - 6'sd5;
    assign w_derr    = !w_is_tok && ((w_acc_upd > 6'sd8) || (w_acc_upd < -6'sd8));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_derr <= 1'b0;
        end else begin
            r_derr <= w_derr;
            if (w_is_tok || w_derr) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_acc_upd;
            end
        end
    end

    assign disp_err = r_derr;
`else
    assign disp_err = 1'b0;
`endif

    assign bitslip    = w_bitslip;
    assign locked     = (r_state == S_LOCKED);
    assign slip_count = r_slip_cnt;
    assign vd         = r_vd;
    assign cd         = r_cd;
    assign vde        = r_vde;

endmodule

// File: tb/tb_tmds_decoder_channel.sv
`timescale 1ns/1ps
module tb_tmds_decoder_channel;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sym_in = 10'h000;
    logic       bitslip;
    logic       locked;
    logic [3:0] slip_count;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
    logic       disp_err;

`ifdef TMDS_DISPARITY_CHECK_EN
    localparam logic DISP_ON = 1'b1;
`else
    localparam logic DISP_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    tmds_decoder_channel dut (
        .clk        (clk),
        .rst        (rst),
        .sym_in     (sym_in),
        .bitslip    (bitslip),
        .locked     (locked),
        .slip_count (slip_count),
        .vd         (vd),
        .cd         (cd),
        .vde        (vde),
        .disp_err   (disp_err)
    );

    // cycle k = the interval after k posedges since reset release
    int unsigned cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    typedef struct {
        int unsigned due;
        logic [7:0]  vd;
        logic [1:0]  cd;
        logic        vde;
        logic        derr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard monitor: outputs for a word appear two cycles after it is driven
    always @(negedge clk) begin
        if (!rst && sb.size() > 0) begin
            if (sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_missed: entry due %0d not seen, now %0d", sb[0].due, cyc);
                void'(sb.pop_front());
            end else if (sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                check("vd",       {24'd0, vd},       {24'd0, mon_e.vd});
                check("cd",       {30'd0, cd},       {30'd0, mon_e.cd});
                check("vde",      {31'd0, vde},      {31'd0, mon_e.vde});
                check("disp_err", {31'd0, disp_err}, {31'd0, mon_e.derr});
            end
        end
    end

    task automatic drive(input logic [9:0] w);
        @(negedge clk);
        sym_in = w;
    endtask

    task automatic expect_dec(input logic [7:0] v, input logic [1:0] c,
                              input logic e, input logic d);
        sb.push_back('{due: cyc + 2, vd: v, cd: c, vde: e, derr: d});
    endtask

    task automatic vec(input logic [9:0] w, input logic [7:0] v, input logic [1:0] c,
                       input logic e, input logic d);
        drive(w);
        expect_dec(v, c, e, d);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"},   {31'd0, locked},     32'd0);
        check({tag, "_slip_cnt"}, {28'd0, slip_count}, 32'd0);
        check({tag, "_vd"},       {24'd0, vd},         32'd0);
        check({tag, "_cd"},       {30'd0, cd},         32'd0);
        check({tag, "_vde"},      {31'd0, vde},        32'd0);
        check({tag, "_bitslip"},  {31'd0, bitslip},    32'd0);
        check({tag, "_disp_err"}, {31'd0, disp_err},   32'd0);
    endtask

    function automatic logic [9:0] rotl10(input logic [9:0] x, input int n);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) r[(i + n) % 10] = x[i];
        return r;
    endfunction

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int unsigned t;
        int          nslip;
        int          off;
        int          lock_cyc;
        int unsigned slip_cyc[$];
        int unsigned exp_slip[3];
        exp_slip = '{2047, 4111, 6175};

        // ---------------- reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // ---------------- lock on aligned tokens, then decode vectors
        @(negedge clk);
        rst    = 1'b0;
        sym_in = 10'h354;
        expect_dec(8'h00, 2'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            vec(10'h354, 8'h00, 2'd0, 1'b0, 1'b0);
            if (k == 8) check("lock_c8",  {31'd0, locked}, 32'd0);
            if (k == 9) check("lock_c9",  {31'd0, locked}, 32'd1);
        end
        vec(10'h100, 8'h00, 2'd0, 1'b1, 1'b0);
        vec(10'h2FF, 8'hFE, 2'd0, 1'b1, 1'b0);
        vec(10'h0AB, 8'h00, 2'd1, 1'b0, 1'b0);
        vec(10'h1FF, 8'h01, 2'd1, 1'b1, 1'b0);
        vec(10'h155, 8'hFF, 2'd1, 1'b1, 1'b0);
        vec(10'h154, 8'h00, 2'd2, 1'b0, 1'b0);
        vec(10'h2AB, 8'h00, 2'd3, 1'b0, 1'b0);
        vec(10'h100, 8'h00, 2'd3, 1'b1, 1'b0);
        // disparity: +5 per 0x3FF word, second in a row overflows; tokens clear
        vec(10'h354, 8'h00, 2'd0, 1'b0, 1'b0);
        vec(10'h3FF, 8'h00, 2'd0, 1'b1, 1'b0);
        vec(10'h3FF, 8'h00, 2'd0, 1'b1, DISP_ON);
        vec(10'h3FF, 8'h00, 2'd0, 1'b1, 1'b0);
        vec(10'h354, 8'h00, 2'd0, 1'b0, 1'b0);
        vec(10'h3FF, 8'h00, 2'd0, 1'b1, 1'b0);
        vec(10'h354, 8'h00, 2'd0, 1'b0, 1'b0);
        vec(10'h3FF, 8'h00, 2'd0, 1'b1, 1'b0);
        vec(10'h1F0, 8'h10, 2'd0, 1'b1, 1'b0);
        check("lock_hold", {31'd0, locked}, 32'd1);

        // ---------------- loss of lock after a full window of data
        vec(10'h354, 8'h00, 2'd0, 1'b0, 1'b0);
        t = cyc;
        for (int k = 1; k < 8; k++) vec(10'h354, 8'h00, 2'd0, 1'b0, 1'b0);
        nslip = 0;
        for (int k = 0; k < 2060; k++) begin
            drive(10'h1F0);
            if (k < 2) expect_dec(8'h10, 2'd0, 1'b1, 1'b0);
            if (bitslip) nslip++;
            if (cyc == t + 2056) check("lol_before", {31'd0, locked}, 32'd1);
            if (cyc == t + 2057) check("lol_after",  {31'd0, locked}, 32'd0);
        end
        check("lol_no_slip", nslip, 0);

        // ---------------- bitslip search with a 3-bit rotated stream
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        off      = 3;
        lock_cyc = -1;
        sym_in   = rotl10(10'h354, off);
        while (cyc < 8000) begin
            @(negedge clk);
            if (bitslip) begin
                slip_cyc.push_back(cyc);
                off = (off + 9) % 10;
            end
            if (locked) begin
                lock_cyc = cyc;
                break;
            end
            sym_in = rotl10(10'h354, off);
        end
        check("slip_pulses", slip_cyc.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < slip_cyc.size()) check("slip_cycle", slip_cyc[i], exp_slip[i]);
        end
        check("slip_lock_cycle", lock_cyc, 6200);
        check("slip_count", {28'd0, slip_count}, 32'd3);

        // ---------------- mid-stream reset while locked
        vec(10'h2AB, 8'h00, 2'd3, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) vec(10'h1F0, 8'h10, 2'd3, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive(10'h1F0);
        check("pre_rst_locked", {31'd0, locked}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");

        // ---------------- 7 tokens do not lock; run event on the expiry cycle wins
        @(negedge clk);
        rst    = 1'b0;
        sym_in = 10'h354;
        nslip  = 0;
        for (int c = 1; c <= 2052; c++) begin
            drive(((c <= 6) || (c >= 2039 && c <= 2046)) ? 10'h354 : 10'h100);
            if (bitslip) nslip++;
            if (c == 20)   check("short_run",   {31'd0, locked}, 32'd0);
            if (c == 2047) check("tie_c2047",   {31'd0, locked}, 32'd0);
            if (c == 2048) check("tie_c2048",   {31'd0, locked}, 32'd1);
        end
        check("tie_no_slip", nslip, 0);
        check("tie_slip_count", {28'd0, slip_count}, 32'd0);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tmds_decoder_channel.md
Name: tmds_decoder_channel

Overview:
- Receive-side counterpart of the TMDS channel encoder: one instance per HDMI/DVI data channel.
- Takes 10-bit parallel words from an external 1:10 deserializer clocked at pixel rate.
- Achieves word alignment by steering the deserializer's bitslip until control tokens are found.
- Decodes each word to 8-bit video data, 2-bit control data and a data-enable, for the RGB capture path.

Parameters:
- LOCK_TOKENS, 8: consecutive control tokens needed to declare (or refresh) lock.
- SEARCH_WINDOW, 2048: cycles allowed without a qualifying token run before a slip (unlocked) or loss of lock (locked). Must exceed one line period.
- SLIP_WAIT, 16: settle cycles after each bitslip pulse.

Ports:
- clk, input, 1: pixel clock (parallel word rate).
- rst, input, 1: asynchronous, active-high reset.
- sym_in, input, 10: deserialized word; bit 0 = first bit on the wire.
- bitslip, output, 1: one-cycle pulse requesting a 1-bit word rotation in the deserializer.
- locked, output, 1: word alignment achieved.
- slip_count, output, 4: number of slips issued, 0..9, wraps 9->0.
- vd, output, 8: decoded video data.
- cd, output, 2: decoded control data {C1,C0}.
- vde, output, 1: 1 = current word is a data symbol, 0 = control token.
- disp_err, output, 1: disparity violation pulse. Only present with the optional feature; otherwise tied 0.

Behaviour:
- Reset: all outputs 0, FSM=SEARCH, all counters 0. Reset is asynchronous and may be applied mid-lock; it returns the block to SEARCH immediately.
- Pipeline:
  - Stage 1 registers sym_in into sym_r.
  - Stage 2 registers the decode of sym_r.
  - Latency from sym_in to vd/cd/vde is exactly 2 cycles. Decode runs every cycle and is not gated by locked.
- Token detect on sym_r:
  - 10'b1101010100 -> cd=00
  - 10'b0010101011 -> cd=01
  - 10'b0101010100 -> cd=10
  - 10'b1010101011 -> cd=11
- Token word: vde=0, vd=0, cd as decoded.
- Non-token word: vde=1, cd holds its last value.
  - d = sym_r[9] ? ~sym_r[7:0] : sym_r[7:0].
  - vd[0] = d[0].
  - For i = 1..7: vd[i] = sym_r[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- run counter:
  - Increments on each token in sym_r and saturates at LOCK_TOKENS.
  - Clears on any non-token word.
  - Hitting LOCK_TOKENS is a "run" event.
- win counter: increments every cycle in SEARCH and LOCKED; clears on a run event or on a state change.
- FSM:
  - SEARCH:
    - run event -> LOCKED; locked=1 from the next cycle.
    - If win reaches SEARCH_WINDOW-1 first: bitslip=1 for one cycle, slip_count increments (mod 10), go to WAIT.
  - WAIT: count SLIP_WAIT cycles with run held at 0 and bitslip=0, then go to SEARCH.
  - LOCKED:
    - run event clears win.
    - If win reaches SEARCH_WINDOW-1: locked=0, go to SEARCH. No slip is issued on this transition.
- Run event and window expiry in the same cycle: the run event wins (no slip, no loss of lock).
- Tokens presented on sym_in cycles 0..7 (no prior run): locked reads 1 in cycle 9.

Optional Feature:
- Macro: TMDS_DISPARITY_CHECK_EN.
- With the macro defined:
  - A signed 6-bit accumulator adds (popcount(sym_r) - 5) for each data word.
  - The accumulator clears on every token.
  - disp_err pulses for one cycle, aligned with the corresponding vd, when the updated accumulator lies outside -8..+8. The accumulator then clears.
- Without the macro: no accumulator logic; disp_err is constant 0.

Test Plan:
- Assert rst mid-stream -> next cycle all outputs 0, locked=0, slip_count=0. After release, 8 tokens 10'h354 are needed to relock.
- Reset released, 8 consecutive 10'h354 on sym_in (cycles 0..7) -> locked=1 at cycle 9; cd=00, vde=0 from cycle 2.
- Locked, sym_in=10'h100 -> vd=8'h00, vde=1 two cycles later. sym_in=10'h2FF -> vd=8'hFE. Token 10'h0AB -> cd=01, vde=0.
- Token stream rotated by 3 bits, with the bench model rotating on each bitslip -> bitslip pulses at cycles 2047, 2047+16+2048, ... Lock achieved after the correct number of slips; slip_count equals that number of slips.
- Locked, then 2048 cycles of data-only words -> locked falls exactly at window expiry; bitslip stays 0.
- With TMDS_DISPARITY_CHECK_EN: repeated 10'h3FF data words -> disp_err pulses on the 2nd word (accumulator 10 > 8). A token between words suppresses the pulse.
